// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares the single frame-buffer RAM port between the VGA line
//               prefetcher (fixed-length read bursts, priority) and the CPU
//               Avalon-MM data master (single beats, starvation guard).
//               Read data is routed back to its owner via a latency pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 24,
    parameter int BURST_LEN  = 16,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic              vid_done,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEAT_W   = $clog2(BURST_LEN);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VBURST    = 2'd1,
        CPU_ISSUE = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                cap_write;
    logic [BEAT_W-1:0]   beat;
    logic [STARVE_W-1:0] starve_cnt;

    // Return pipe: one entry per memory cycle; owner 1 = CPU, 0 = video.
    logic [RD_LAT-1:0]   sr_valid;
    logic [RD_LAT-1:0]   sr_owner;
    logic [RD_LAT-1:0]   sr_last;

    logic cpu_pending;
    logic in_burst;
    logic in_cpu;
    logic ret_valid;
    logic ret_owner;

    assign cpu_pending = cpu_read | cpu_write;
    assign in_burst    = (state == VBURST);
    assign in_cpu      = (state == CPU_ISSUE);

    // Memory strobes come from state and capture registers only, so no
    // master input ever reaches the memory port combinationally.
    assign mem_rd          = in_burst | (in_cpu & ~cap_write);
    assign mem_wr          = in_cpu & cap_write;
    assign mem_addr        = in_burst ? (base_addr + ADDR_W'(beat)) : cap_addr;
    assign mem_wdata       = cap_wdata;
    assign cpu_waitrequest = ~in_cpu;
    assign vid_ack         = in_burst & (beat == '0);

    assign ret_valid = sr_valid[RD_LAT-1];
    assign ret_owner = sr_owner[RD_LAT-1];

    // Arbitration FSM with capture registers and starvation counter.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state      <= IDLE;
            base_addr  <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_write  <= 1'b0;
            beat       <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (vid_req && (starve_cnt < STARVE_LIM)) begin
                        state     <= VBURST;
                        base_addr <= vid_addr;
                        // Below the limit here, so the increment cannot overshoot.
                        if (cpu_pending) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                    end else if (cpu_pending) begin
                        state      <= CPU_ISSUE;
                        cap_addr   <= cpu_addr;
                        cap_wdata  <= cpu_writedata;
                        // Read and write together: the write wins.
                        cap_write  <= cpu_write;
                        starve_cnt <= '0;
                    end else if (vid_req) begin
                        state     <= VBURST;
                        base_addr <= vid_addr;
                    end
                end
                VBURST: begin
                    beat <= beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                    end
                end
                CPU_ISSUE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Latency pipe tracking owner and last-beat flag of every issued read.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sr_valid <= '0;
            sr_owner <= '0;
            sr_last  <= '0;
        end else begin
            sr_valid[0] <= mem_rd;
            sr_owner[0] <= in_cpu;
            sr_last[0]  <= in_burst & (beat == LAST_BEAT);
            for (int i = 1; i < RD_LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_owner[i] <= sr_owner[i-1];
                sr_last[i]  <= sr_last[i-1];
            end
        end
    end

    // Register returning memory data into its owner's output.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            vid_rdata         <= '0;
            vid_rvalid        <= 1'b0;
            vid_done          <= 1'b0;
            cpu_readdata      <= '0;
            cpu_readdatavalid <= 1'b0;
        end else begin
            vid_rvalid        <= ret_valid & ~ret_owner;
            vid_done          <= ret_valid & ~ret_owner & sr_last[RD_LAT-1];
            cpu_readdatavalid <= ret_valid & ret_owner;
            if (ret_valid && !ret_owner) begin
                vid_rdata <= mem_rdata;
            end
            if (ret_valid && ret_owner) begin
                cpu_readdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
